// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a 64-bit word array; serves one full read or write burst at a time.
// Bundles a minimal ariane_axi package so the responder is self-contained.
package ariane_axi;
  localparam int unsigned IdWidth = 4;
  typedef logic [IdWidth-1:0] id_t;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef struct packed {
    id_t         id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t         id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    id_t         id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_mem_responder #(
  parameter int unsigned NumWords = 1024,
  parameter logic [63:0] BaseAddr = 64'h0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  ariane_axi::req_t  axi_req_i,
  output ariane_axi::resp_t axi_resp_o
);
  import ariane_axi::*;

  localparam int unsigned IdxW = $clog2(NumWords);

  typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_e;

  state_e      state_q, state_d;
  logic        ptr_read_q, ptr_read_d;
  id_t         id_q, id_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        atop_q, atop_d;
  logic        slv_err_q, slv_err_d;
  logic        dec_err_q, dec_err_d;
  logic        ovf_q, ovf_d;

  logic [63:0] mem_q [NumWords];

  logic [63:0]     offset, step, wrap_mask, next_addr;
  logic [64:0]     incr_sum;
  logic            next_ovf, in_range, last_beat, mem_we, aw_grant, ar_grant;
  logic [IdxW-1:0] idx;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) || ((burst == BurstWrap) && !wrap_len_ok(len));
  endfunction

  // Once an increment carries past 2^64 the rest of the burst stays out of range.
  always_comb begin
    offset    = addr_q - BaseAddr;
    in_range  = !ovf_q && (addr_q >= BaseAddr) && ((offset >> 3) < 64'(NumWords));
    idx       = offset[IdxW+2:3];
    step      = 64'd1 << size_q;
    incr_sum  = {1'b0, addr_q} + {1'b0, step};
    wrap_mask = ((64'(len_q) + 64'd1) << size_q) - 64'd1;
    next_addr = incr_sum[63:0];
    next_ovf  = ovf_q | incr_sum[64];
    if (burst_q == BurstFixed) begin
      next_addr = addr_q;
      next_ovf  = ovf_q;
    end else if ((burst_q == BurstWrap) && wrap_len_ok(len_q)) begin
      next_addr = (addr_q & ~wrap_mask) | (incr_sum[63:0] & wrap_mask);
      next_ovf  = ovf_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_read_d = ptr_read_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    size_d     = size_q;
    burst_d    = burst_q;
    atop_d     = atop_q;
    slv_err_d  = slv_err_q;
    dec_err_d  = dec_err_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    aw_grant   = 1'b0;
    ar_grant   = 1'b0;
    last_beat  = (beat_q == len_q);
    axi_resp_o = '0;

    unique case (state_q)
      IDLE: begin
        aw_grant = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !ptr_read_q);
        ar_grant = axi_req_i.ar_valid && (!axi_req_i.aw_valid || ptr_read_q);
        axi_resp_o.aw_ready = aw_grant;
        axi_resp_o.ar_ready = ar_grant;
        if (axi_req_i.aw_valid && axi_req_i.ar_valid) ptr_read_d = !ptr_read_q;
        beat_d    = '0;
        dec_err_d = 1'b0;
        ovf_d     = 1'b0;
        if (aw_grant) begin
          id_d      = axi_req_i.aw.id;
          addr_d    = axi_req_i.aw.addr;
          len_d     = axi_req_i.aw.len;
          size_d    = axi_req_i.aw.size;
          burst_d   = axi_req_i.aw.burst;
          atop_d    = |axi_req_i.aw.atop;
          slv_err_d = burst_err(axi_req_i.aw.burst, axi_req_i.aw.len) || (|axi_req_i.aw.atop);
          state_d   = WRITE;
        end else if (ar_grant) begin
          id_d      = axi_req_i.ar.id;
          addr_d    = axi_req_i.ar.addr;
          len_d     = axi_req_i.ar.len;
          size_d    = axi_req_i.ar.size;
          burst_d   = axi_req_i.ar.burst;
          atop_d    = 1'b0;
          slv_err_d = burst_err(axi_req_i.ar.burst, axi_req_i.ar.len);
          state_d   = READ;
        end
      end
      WRITE: begin
        axi_resp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          if (!in_range) dec_err_d = 1'b1;
          else if (!atop_q) mem_we = 1'b1;
          if (axi_req_i.w.last != last_beat) slv_err_d = 1'b1;
          addr_d = next_addr;
          ovf_d  = next_ovf;
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        axi_resp_o.b_valid = 1'b1;
        axi_resp_o.b.id    = id_q;
        axi_resp_o.b.resp  = dec_err_q ? RespDecErr : (slv_err_q ? RespSlvErr : RespOkay);
        if (axi_req_i.b_ready) state_d = IDLE;
      end
      READ: begin
        axi_resp_o.r_valid = 1'b1;
        axi_resp_o.r.id    = id_q;
        axi_resp_o.r.data  = in_range ? mem_q[idx] : '0;
        axi_resp_o.r.resp  = !in_range ? RespDecErr : (slv_err_q ? RespSlvErr : RespOkay);
        axi_resp_o.r.last  = last_beat;
        if (axi_req_i.r_ready) begin
          addr_d = next_addr;
          ovf_d  = next_ovf;
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = IDLE;
        end
      end
    endcase

    // Readies are combinational on the valids, so they must be forced low while reset is held.
    if (!rst_ni) axi_resp_o = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_read_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      atop_q     <= 1'b0;
      slv_err_q  <= 1'b0;
      dec_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_read_q <= ptr_read_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      atop_q     <= atop_d;
      slv_err_q  <= slv_err_d;
      dec_err_q  <= dec_err_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (axi_req_i.w.strb[i]) mem_q[idx][8*i +: 8] <= axi_req_i.w.data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a transaction table plus hand-written
// sequences for arbitration, read backpressure and reset mid-burst.
module tb_axi_mem_responder;
  import ariane_axi::*;

  localparam int unsigned NumWords = 16;
  localparam logic [63:0] BaseAddr = 64'h1000;
  localparam int          NumVecs  = 20;

  logic  clk = 1'b0;
  logic  rst_n;
  req_t  req;
  resp_t resp;
  int    tests_run = 0;
  int    tests_failed = 0;

  always #5 clk = ~clk;

  axi_mem_responder #(.NumWords(NumWords), .BaseAddr(BaseAddr)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .axi_req_i  (req),
    .axi_resp_o (resp)
  );

  // early_last = 8'hFF means w.last is only raised on the final beat.
  typedef struct packed {
    logic             is_write;
    logic [3:0]       id;
    logic [63:0]      addr;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [5:0]       atop;
    logic [7:0]       strb;
    logic [7:0]       early_last;
    logic [3:0][63:0] data;
    logic [3:0][1:0]  resp;
  } vec_t;

  vec_t vecs [NumVecs];

  function automatic vec_t mk_w(logic [3:0] id, logic [63:0] addr, logic [7:0] len,
                                logic [1:0] burst, logic [5:0] atop, logic [7:0] strb,
                                logic [7:0] early, logic [63:0] d0, logic [63:0] d1,
                                logic [63:0] d2, logic [1:0] bresp);
    vec_t v = '0;
    v.is_write = 1'b1; v.id = id; v.addr = addr; v.len = len; v.burst = burst;
    v.atop = atop; v.strb = strb; v.early_last = early;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = 64'h4;
    v.resp[0] = bresp;
    return v;
  endfunction

  function automatic vec_t mk_r(logic [3:0] id, logic [63:0] addr, logic [7:0] len,
                                logic [1:0] burst, logic [63:0] d0, logic [63:0] d1,
                                logic [63:0] d2, logic [63:0] d3, logic [1:0] r0,
                                logic [1:0] r1);
    vec_t v = '0;
    v.is_write = 1'b0; v.id = id; v.addr = addr; v.len = len; v.burst = burst;
    v.early_last = 8'hFF;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
    v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = 2'b00; v.resp[3] = 2'b00;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    logic got;
    int   wbeats;
    @(negedge clk);
    got = 1'b0;
    if (v.is_write) begin
      req.aw       = '0;
      req.aw.id    = v.id;
      req.aw.addr  = v.addr;
      req.aw.len   = v.len;
      req.aw.size  = 3'd3;
      req.aw.burst = v.burst;
      req.aw.atop  = v.atop;
      req.aw_valid = 1'b1;
    end else begin
      req.ar       = '0;
      req.ar.id    = v.id;
      req.ar.addr  = v.addr;
      req.ar.len   = v.len;
      req.ar.size  = 3'd3;
      req.ar.burst = v.burst;
      req.ar_valid = 1'b1;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (v.is_write ? resp.aw_ready : resp.ar_ready) got = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput($sformatf("v%0d addr handshake", n), 64'(got), 64'd1);
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;

    if (v.is_write) begin
      wbeats = 0;
      for (int b = 0; b <= int'(v.len); b++) begin
        req.w.data  = v.data[b];
        req.w.strb  = v.strb;
        req.w.last  = (b == int'(v.len)) || (b == int'(v.early_last));
        req.w_valid = 1'b1;
        #1;
        if (resp.w_ready && !resp.b_valid) wbeats++;
        @(posedge clk);
        @(negedge clk);
      end
      req.w_valid = 1'b0;
      req.w.last  = 1'b0;
      checkOutput($sformatf("v%0d w beats", n), 64'(wbeats), 64'(int'(v.len) + 1));
      #1;
      checkOutput($sformatf("v%0d b_valid", n), 64'(resp.b_valid), 64'd1);
      checkOutput($sformatf("v%0d b.resp", n), 64'(resp.b.resp), 64'(v.resp[0]));
      checkOutput($sformatf("v%0d b.id", n), 64'(resp.b.id), 64'(v.id));
      req.b_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req.b_ready = 1'b0;
      #1;
      checkOutput($sformatf("v%0d b_valid drop", n), 64'(resp.b_valid), 64'd0);
    end else begin
      req.r_ready = 1'b1;
      for (int b = 0; b <= int'(v.len); b++) begin
        #1;
        checkOutput($sformatf("v%0d beat%0d r_valid", n, b), 64'(resp.r_valid), 64'd1);
        checkOutput($sformatf("v%0d beat%0d r.data", n, b), resp.r.data, v.data[b]);
        checkOutput($sformatf("v%0d beat%0d r.resp", n, b), 64'(resp.r.resp), 64'(v.resp[b]));
        checkOutput($sformatf("v%0d beat%0d r.id", n, b), 64'(resp.r.id), 64'(v.id));
        checkOutput($sformatf("v%0d beat%0d r.last", n, b), 64'(resp.r.last),
                    64'(b == int'(v.len)));
        @(posedge clk);
        @(negedge clk);
      end
      req.r_ready = 1'b0;
      #1;
      checkOutput($sformatf("v%0d r_valid drop", n), 64'(resp.r_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beat;
    logic rr;

    vecs[0]  = mk_w(4'd3, 64'h1010, 8'd0, BurstIncr, 6'd0, 8'hFF, 8'hFF,
                    64'hDEADBEEF_01234567, 64'h0, 64'h0, 2'b00);
    vecs[1]  = mk_r(4'd5, 64'h1010, 8'd0, BurstIncr, 64'hDEADBEEF_01234567, 64'h0, 64'h0, 64'h0,
                    2'b00, 2'b00);
    vecs[2]  = mk_w(4'd1, 64'h1020, 8'd3, BurstIncr, 6'd0, 8'hFF, 8'hFF,
                    64'h1, 64'h2, 64'h3, 2'b00);
    vecs[3]  = mk_w(4'd2, 64'h1040, 8'd3, BurstIncr, 6'd0, 8'hFF, 8'hFF,
                    64'hAAAAAAAA_AAAAAA40, 64'hAAAAAAAA_AAAAAA48, 64'hAAAAAAAA_AAAAAA50, 2'b00);
    vecs[3].data[3] = 64'hAAAAAAAA_AAAAAA58;
    vecs[4]  = mk_r(4'd6, 64'h1050, 8'd3, BurstWrap, 64'hAAAAAAAA_AAAAAA50, 64'hAAAAAAAA_AAAAAA58,
                    64'hAAAAAAAA_AAAAAA40, 64'hAAAAAAAA_AAAAAA48, 2'b00, 2'b00);
    vecs[5]  = mk_w(4'd0, 64'h1060, 8'd0, BurstIncr, 6'd0, 8'hFF, 8'hFF,
                    64'hAAAAAAAA_AAAAAAAA, 64'h0, 64'h0, 2'b00);
    vecs[6]  = mk_w(4'd0, 64'h1060, 8'd0, BurstIncr, 6'd0, 8'h0F, 8'hFF,
                    64'h11223344_55667788, 64'h0, 64'h0, 2'b00);
    vecs[7]  = mk_r(4'd7, 64'h1060, 8'd0, BurstIncr, 64'hAAAAAAAA_55667788, 64'h0, 64'h0, 64'h0,
                    2'b00, 2'b00);
    vecs[8]  = mk_r(4'd8, 64'h1080, 8'd0, BurstIncr, 64'h0, 64'h0, 64'h0, 64'h0, 2'b11, 2'b00);
    vecs[9]  = mk_r(4'd9, 64'h0FF8, 8'd0, BurstIncr, 64'h0, 64'h0, 64'h0, 64'h0, 2'b11, 2'b00);
    vecs[10] = mk_w(4'd7, 64'h1000, 8'd2, BurstIncr, 6'd0, 8'h00, 8'd1,
                    64'h7, 64'h8, 64'h9, 2'b10);
    vecs[11] = mk_w(4'd9, 64'h1068, 8'd1, BurstFixed, 6'd0, 8'hFF, 8'hFF,
                    64'h111, 64'h222, 64'h0, 2'b00);
    vecs[12] = mk_r(4'd10, 64'h1068, 8'd0, BurstIncr, 64'h222, 64'h0, 64'h0, 64'h0, 2'b00, 2'b00);
    vecs[13] = mk_w(4'd11, 64'h1010, 8'd0, BurstIncr, 6'h20, 8'hFF, 8'hFF,
                    64'h0, 64'h0, 64'h0, 2'b10);
    vecs[14] = mk_r(4'd12, 64'h1010, 8'd0, BurstIncr, 64'hDEADBEEF_01234567, 64'h0, 64'h0, 64'h0,
                    2'b00, 2'b00);
    vecs[15] = mk_w(4'd13, 64'h1000, 8'd2, BurstWrap, 6'd0, 8'h00, 8'hFF,
                    64'h0, 64'h0, 64'h0, 2'b10);
    vecs[16] = mk_w(4'd14, 64'h1078, 8'd1, BurstIncr, 6'd0, 8'hFF, 8'd0,
                    64'h7878, 64'h9999, 64'h0, 2'b11);
    vecs[17] = mk_r(4'd15, 64'h1078, 8'd1, BurstIncr, 64'h7878, 64'h0, 64'h0, 64'h0,
                    2'b00, 2'b11);
    vecs[18] = mk_w(4'd2, 64'h1000, 8'd0, 2'b11, 6'd0, 8'h00, 8'hFF,
                    64'h0, 64'h0, 64'h0, 2'b10);
    vecs[19] = mk_r(4'd3, 64'h1048, 8'd1, BurstWrap, 64'hAAAAAAAA_AAAAAA48, 64'hAAAAAAAA_AAAAAA40,
                    64'h0, 64'h0, 2'b00, 2'b00);

    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    #1;
    checkOutput("reset aw_ready", 64'(resp.aw_ready), 64'd0);
    checkOutput("reset ar_ready", 64'(resp.ar_ready), 64'd0);
    checkOutput("reset w_ready", 64'(resp.w_ready), 64'd0);
    checkOutput("reset b_valid", 64'(resp.b_valid), 64'd0);
    checkOutput("reset r_valid", 64'(resp.r_valid), 64'd0);
    checkOutput("reset r.data", resp.r.data, 64'd0);
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;

    // Arbitration: both valid twice in a row goes write first, then read.
    @(negedge clk);
    req.aw.id = 4'd1; req.aw.addr = 64'h1000; req.aw.size = 3'd3; req.aw.burst = BurstIncr;
    req.ar.id = 4'd2; req.ar.addr = 64'h1000; req.ar.size = 3'd3; req.ar.burst = BurstIncr;
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    #1;
    checkOutput("arb1 aw_ready", 64'(resp.aw_ready), 64'd1);
    checkOutput("arb1 ar_ready", 64'(resp.ar_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w.data = 64'h5A5A_0000_1111_A5A5; req.w.strb = 8'hFF; req.w.last = 1'b1;
    req.w_valid = 1'b1;
    #1;
    checkOutput("arb busy ar_ready", 64'(resp.ar_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req.w_valid = 1'b0;
    req.w.last  = 1'b0;
    #1;
    checkOutput("arb b_valid", 64'(resp.b_valid), 64'd1);
    checkOutput("arb b.id", 64'(resp.b.id), 64'd1);
    req.b_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req.b_ready  = 1'b0;
    req.aw_valid = 1'b1;
    #1;
    checkOutput("arb2 ar_ready", 64'(resp.ar_ready), 64'd1);
    checkOutput("arb2 aw_ready", 64'(resp.aw_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b1;
    #1;
    checkOutput("arb r_valid", 64'(resp.r_valid), 64'd1);
    checkOutput("arb r.data", resp.r.data, 64'h5A5A_0000_1111_A5A5);
    @(posedge clk);
    @(negedge clk);
    req.r_ready = 1'b0;

    for (int i = 0; i < NumVecs; i++) applyStimulus(vecs[i], i);

    // Read backpressure: r_ready toggles 1,0,1,0 and stalled beats must hold.
    @(negedge clk);
    req.ar = '0;
    req.ar.id = 4'd4; req.ar.addr = 64'h1020; req.ar.len = 8'd3; req.ar.size = 3'd3;
    req.ar.burst = BurstIncr;
    req.ar_valid = 1'b1;
    #1;
    checkOutput("bp ar_ready", 64'(resp.ar_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    beat = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      rr = (c % 2 == 0);
      req.r_ready = rr;
      #1;
      checkOutput($sformatf("bp c%0d r_valid", c), 64'(resp.r_valid), 64'd1);
      checkOutput($sformatf("bp c%0d r.data", c), resp.r.data, 64'(beat + 1));
      checkOutput($sformatf("bp c%0d r.last", c), 64'(resp.r.last), 64'(beat == 3));
      if (rr) beat++;
      @(posedge clk);
      @(negedge clk);
    end
    req.r_ready = 1'b0;
    checkOutput("bp beats", 64'(beat), 64'd4);

    // Reset during beat 2 of an 8-beat read, then a fresh AR from IDLE.
    req.ar = '0;
    req.ar.id = 4'd6; req.ar.addr = 64'h1000; req.ar.len = 8'd7; req.ar.size = 3'd3;
    req.ar.burst = BurstIncr;
    req.ar_valid = 1'b1;
    #1;
    checkOutput("rst ar_ready", 64'(resp.ar_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    req.ar_valid = 1'b1;
    req.aw_valid = 1'b1;
    #1;
    checkOutput("midrst r_valid", 64'(resp.r_valid), 64'd0);
    checkOutput("midrst ar_ready", 64'(resp.ar_ready), 64'd0);
    checkOutput("midrst aw_ready", 64'(resp.aw_ready), 64'd0);
    checkOutput("midrst r.data", resp.r.data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req.aw_valid = 1'b0;
    req.r_ready  = 1'b0;
    req.ar.id = 4'd2; req.ar.addr = 64'h1010; req.ar.len = 8'd0;
    #1;
    checkOutput("postrst ar_ready", 64'(resp.ar_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b1;
    #1;
    checkOutput("postrst r_valid", 64'(resp.r_valid), 64'd1);
    checkOutput("postrst r.data", resp.r.data, 64'hDEADBEEF_01234567);
    checkOutput("postrst r.id", 64'(resp.r.id), 64'd2);
    checkOutput("postrst r.last", 64'(resp.r.last), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req.r_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
